// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } tx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 9;

  // Mode 2'b11 is deliberately treated as no parity.
  function automatic logic parity_enabled(logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

  function automatic logic calc_parity(logic data_xor, logic [1:0] mode);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_hold_reg.sv
// One-entry valid/ready holding register; take empties it, load fills it when empty.
module uart_tx_hold_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [Width-1:0] load_data_i,
  input  logic             take_i,
  output logic             full_o,
  output logic [Width-1:0] data_o
);

  logic             full_q, full_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (take_i) full_d = 1'b0;
    if (load_valid_i && !full_q) begin
      full_d = 1'b1;
      data_d = load_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign load_ready_o = ~full_q;
  assign full_o       = full_q;
  assign data_o       = data_q;

endmodule

// File: rtl/uart_tx_param.sv
// UART transmitter: LSB-first words with per-frame parity and stop-bit count,
// advanced by a one-cycle baud tick, fed through a one-entry holding register.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_Baud_Tick,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_Two_Stop,
  input  logic                 i_Tx_Valid,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Data,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done
);

  localparam int unsigned CntW  = $clog2(DATA_BITS);
  localparam int unsigned HoldW = DATA_BITS + 3;

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : gen_bad_width
    $error("uart_tx_param: DATA_BITS outside legal range");
  end

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 two_stop_q, two_stop_d;

  logic                 hold_full;
  logic [HoldW-1:0]     hold_data;
  logic                 start_frame;
  logic                 frame_end;
  logic                 last_bit;

  uart_tx_hold_reg #(
    .Width(HoldW)
  ) u_hold (
    .clk         (clk),
    .reset       (reset),
    .load_valid_i(i_Tx_Valid),
    .load_ready_o(o_Tx_Ready),
    .load_data_i ({i_Two_Stop, i_Parity_Mode, i_Tx_Byte}),
    .take_i      (start_frame),
    .full_o      (hold_full),
    .data_o      (hold_data)
  );

  assign last_bit = (cnt_q == CntW'(DATA_BITS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_end   = 1'b0;
    start_frame = 1'b0;
    if (i_Baud_Tick) begin
      case (state_q)
        StIdle:   if (hold_full) state_d = StStart;
        StStart:  state_d = StData;
        StData:   if (last_bit) state_d = par_en_q ? StParity : StStop1;
        StParity: state_d = StStop1;
        StStop1:  begin
          if (two_stop_q) state_d = StStop2;
          else            frame_end = 1'b1;
        end
        StStop2:  frame_end = 1'b1;
        default:  state_d = StIdle;
      endcase
      if (frame_end) state_d = hold_full ? StStart : StIdle;
      start_frame = hold_full && ((state_q == StIdle) || frame_end);
    end
  end

  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    if (i_Baud_Tick) begin
      case (state_q)
        StStart: begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
        end
        StData: begin
          if (!last_bit) begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CntW'(1);
          end else begin
            tx_d = par_en_q ? par_bit_q : 1'b1;
          end
        end
        StParity, StStop1, StStop2: tx_d = 1'b1;
        default: ;
      endcase
      done_d = frame_end;
      // A queued word starts on the same tick that closes the previous frame.
      if (start_frame) begin
        shift_d    = hold_data[DATA_BITS-1:0];
        par_en_d   = parity_enabled(hold_data[DATA_BITS +: 2]);
        par_bit_d  = calc_parity(^hold_data[DATA_BITS-1:0], hold_data[DATA_BITS +: 2]);
        two_stop_d = hold_data[DATA_BITS+2];
        tx_d       = 1'b0;
      end
    end
  end

  always_comb begin
    o_Tx_Active = (state_q != StIdle);
    o_Tx_Data   = tx_q;
    o_Tx_Done   = done_q;
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param (8-bit and 7-bit instances).
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [8:0] tx_byte;
  logic [1:0] par_mode;
  logic       two_stop;
  logic       valid;
  logic       use7;

  logic ready8, line8, active8, done8;
  logic ready7, line7, active7, done7;
  logic mon_ready, mon_line, mon_active, mon_done;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8)) u_dut8 (
    .clk          (clk),
    .reset        (reset),
    .i_Baud_Tick  (tick),
    .i_Tx_Byte    (tx_byte[7:0]),
    .i_Parity_Mode(par_mode),
    .i_Two_Stop   (two_stop),
    .i_Tx_Valid   (valid & ~use7),
    .o_Tx_Ready   (ready8),
    .o_Tx_Data    (line8),
    .o_Tx_Active  (active8),
    .o_Tx_Done    (done8)
  );

  uart_tx_param #(.DATA_BITS(7)) u_dut7 (
    .clk          (clk),
    .reset        (reset),
    .i_Baud_Tick  (tick),
    .i_Tx_Byte    (tx_byte[6:0]),
    .i_Parity_Mode(par_mode),
    .i_Two_Stop   (two_stop),
    .i_Tx_Valid   (valid & use7),
    .o_Tx_Ready   (ready7),
    .o_Tx_Data    (line7),
    .o_Tx_Active  (active7),
    .o_Tx_Done    (done7)
  );

  assign mon_ready  = use7 ? ready7  : ready8;
  assign mon_line   = use7 ? line7   : line8;
  assign mon_active = use7 ? active7 : active8;
  assign mon_done   = use7 ? done7   : done8;

  // Tick held high; sends n (1 or 2) words and records the line during active cycles.
  task automatic run_words(input int n, input logic [8:0] w0, input logic [8:0] w1,
                           input logic [1:0] mode, input logic two,
                           output logic [31:0] bits, output int len, output int ndone,
                           output int d0, output int d1, output int first_act);
    int   sent;
    logic xfer;
    sent = 0; bits = '0; len = 0; ndone = 0; d0 = -1; d1 = -1; first_act = -1;
    tick = 1'b1; tx_byte = w0; par_mode = mode; two_stop = two; valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      xfer = valid && mon_ready;
      @(negedge clk);
      if (xfer) begin
        sent++;
        if (sent < n) tx_byte = w1;
        else          valid = 1'b0;
      end
      if (mon_done) begin
        ndone++;
        if (d0 < 0) d0 = c;
        else        d1 = c;
      end
      if (mon_active) begin
        if (first_act < 0) first_act = c;
        if (len < 32) bits[len] = mon_line;
        len++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; valid = 1'b0; tx_byte = '0; par_mode = 2'b00;
    two_stop = 1'b0; use7 = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (line8 !== 1'b1) begin n_fail++; $display("FAIL rst_line: got %b want 1", line8); end
    n_cmp++; if (active8 !== 1'b0) begin n_fail++; $display("FAIL rst_active: got %b want 0", active8); end
    n_cmp++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done8); end
    n_cmp++; if (ready8 !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", ready8); end
    reset = 1'b0; tick = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if ({line8, active8, done8} !== 3'b100) begin
      n_fail++; $display("FAIL idle_tick: got %b want 100", {line8, active8, done8});
    end
  endtask

  task automatic test_8n1();
    logic [31:0] bits; int len, nd, d0, d1, fa;
    run_words(1, 9'h055, 9'h000, 2'b00, 1'b0, bits, len, nd, d0, d1, fa);
    n_cmp++; if (bits !== 32'h2AA) begin n_fail++; $display("FAIL 8n1_bits: got %h want 2aa", bits); end
    n_cmp++; if (len !== 10) begin n_fail++; $display("FAIL 8n1_active_len: got %0d want 10", len); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL 8n1_done_count: got %0d want 1", nd); end
    n_cmp++; if (fa !== 1) begin n_fail++; $display("FAIL 8n1_start_latency: got %0d want 1", fa); end
    n_cmp++; if (d0 !== 11) begin n_fail++; $display("FAIL 8n1_done_cycle: got %0d want 11", d0); end
  endtask

  task automatic test_parity();
    logic [31:0] bits; int len, nd, d0, d1, fa;
    run_words(1, 9'h0A5, 9'h000, 2'b10, 1'b0, bits, len, nd, d0, d1, fa);
    n_cmp++; if (bits !== 32'h54A) begin n_fail++; $display("FAIL even_bits: got %h want 54a", bits); end
    n_cmp++; if (len !== 11) begin n_fail++; $display("FAIL even_len: got %0d want 11", len); end
    run_words(1, 9'h0A5, 9'h000, 2'b01, 1'b0, bits, len, nd, d0, d1, fa);
    n_cmp++; if (bits !== 32'h74A) begin n_fail++; $display("FAIL odd_bits: got %h want 74a", bits); end
    n_cmp++; if (len !== 11) begin n_fail++; $display("FAIL odd_len: got %0d want 11", len); end
    n_cmp++; if (d0 !== 12) begin n_fail++; $display("FAIL odd_done_cycle: got %0d want 12", d0); end
    run_words(1, 9'h055, 9'h000, 2'b11, 1'b0, bits, len, nd, d0, d1, fa);
    n_cmp++; if (bits !== 32'h2AA) begin n_fail++; $display("FAIL mode3_bits: got %h want 2aa", bits); end
    n_cmp++; if (len !== 10) begin n_fail++; $display("FAIL mode3_len: got %0d want 10", len); end
  endtask

  task automatic test_seven_two_stop();
    logic [31:0] bits; int len, nd, d0, d1, fa;
    use7 = 1'b1;
    run_words(1, 9'h03F, 9'h000, 2'b00, 1'b1, bits, len, nd, d0, d1, fa);
    use7 = 1'b0;
    n_cmp++; if (bits !== 32'h37E) begin n_fail++; $display("FAIL 7b2s_bits: got %h want 37e", bits); end
    n_cmp++; if (len !== 10) begin n_fail++; $display("FAIL 7b2s_len: got %0d want 10", len); end
    n_cmp++; if (d0 !== 11) begin n_fail++; $display("FAIL 7b2s_done_cycle: got %0d want 11", d0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bits; int len, nd, d0, d1, fa;
    run_words(2, 9'h001, 9'h080, 2'b00, 1'b0, bits, len, nd, d0, d1, fa);
    n_cmp++; if (bits !== 32'hC0202) begin n_fail++; $display("FAIL b2b_bits: got %h want c0202", bits); end
    n_cmp++; if (len !== 20) begin n_fail++; $display("FAIL b2b_len: got %0d want 20", len); end
    n_cmp++; if (nd !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", nd); end
    n_cmp++; if (d0 !== 11) begin n_fail++; $display("FAIL b2b_done0: got %0d want 11", d0); end
    n_cmp++; if (d1 !== 21) begin n_fail++; $display("FAIL b2b_done1: got %0d want 21", d1); end
  endtask

  task automatic test_slow_tick();
    int   sent, x2, x3, dcnt, dc, line_err, ready_hi;
    logic xfer, line175;
    logic [9:0] pat;
    pat = 10'h2AA; sent = 0; x2 = -1; x3 = -1; dcnt = 0; dc = -1; line_err = 0;
    ready_hi = 0; line175 = 1'bx;
    tx_byte = 9'h055; par_mode = 2'b00; two_stop = 1'b0; valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick = (c % 16 == 15);
      xfer = valid && mon_ready;
      @(negedge clk);
      if (xfer) begin
        sent++;
        if (sent == 1) tx_byte = 9'h00F;
        if (sent == 2) begin x2 = c; tx_byte = 9'h0FF; end
        if (sent == 3) begin x3 = c; valid = 1'b0; end
      end
      if (mon_done) begin dcnt++; if (dc < 0) dc = c; end
      if (c >= 15 && c < 175 && mon_line !== pat[(c - 15) / 16]) line_err++;
      if (c >= 17 && c < 175 && mon_ready) ready_hi++;
      if (c == 175) line175 = mon_line;
    end
    n_cmp++; if (line_err !== 0) begin n_fail++; $display("FAIL slow_bit_hold: got %0d bad cycles want 0", line_err); end
    n_cmp++; if (ready_hi !== 0) begin n_fail++; $display("FAIL slow_ready_low: got %0d ready cycles want 0", ready_hi); end
    n_cmp++; if (x2 !== 16) begin n_fail++; $display("FAIL slow_accept2: got %0d want 16", x2); end
    n_cmp++; if (x3 !== 176) begin n_fail++; $display("FAIL slow_accept3: got %0d want 176", x3); end
    n_cmp++; if (dc !== 175) begin n_fail++; $display("FAIL slow_done_cycle: got %0d want 175", dc); end
    n_cmp++; if (dcnt !== 1) begin n_fail++; $display("FAIL slow_done_width: got %0d want 1", dcnt); end
    n_cmp++; if (line175 !== 1'b0) begin n_fail++; $display("FAIL slow_next_start: got %b want 0", line175); end
    tick = 1'b1;
    repeat (60) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] bits; int len, nd, d0, d1, fa, ndone, nlow;
    tick = 1'b1; tx_byte = 9'h0F0; par_mode = 2'b00; two_stop = 1'b0; valid = 1'b1;
    @(negedge clk);
    tx_byte = 9'h033;
    @(negedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({line8, active8, ready8} !== 3'b010) begin
      n_fail++; $display("FAIL mid_pre_reset: got %b want 010", {line8, active8, ready8});
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if ({line8, active8, done8} !== 3'b100) begin
      n_fail++; $display("FAIL mid_reset_line: got %b want 100", {line8, active8, done8});
    end
    ndone = 0; nlow = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done8) ndone++;
      if (!line8) nlow++;
    end
    n_cmp++; if (ndone !== 0) begin n_fail++; $display("FAIL mid_no_done: got %0d want 0", ndone); end
    n_cmp++; if (nlow !== 0) begin n_fail++; $display("FAIL mid_held_dropped: got %0d low cycles want 0", nlow); end
    n_cmp++; if (ready8 !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", ready8); end
    run_words(1, 9'h055, 9'h000, 2'b00, 1'b0, bits, len, nd, d0, d1, fa);
    n_cmp++; if (bits !== 32'h2AA) begin n_fail++; $display("FAIL post_reset_bits: got %h want 2aa", bits); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL post_reset_done: got %0d want 1", nd); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_seven_two_stop();
    test_back_to_back();
    test_slow_tick();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter: serialises words of `DATA_BITS` bits, LSB first, with per-frame selectable parity and one or two stop bits. It runs on the system clock with a one-cycle baud-tick enable. A one-entry holding register gives a valid/ready input and lets frames go back-to-back with no idle gap. It sits between the baud rate generator (tick source) and the pad, and replaces the fixed 8N1 transmitter in new designs.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5..9.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_Baud_Tick`  in  1  one-cycle pulse per bit period; may be held high (one bit per clk).
- `i_Tx_Byte`  in  DATA_BITS  word to send.
- `i_Parity_Mode`  in  2  00 none, 01 odd, 10 even, 11 treated as none.
- `i_Two_Stop`  in  1  1 = two stop bits, 0 = one.
- `i_Tx_Valid`  in  1  word and config present.
- `o_Tx_Ready`  out  1  holding register empty; transfer when `i_Tx_Valid & o_Tx_Ready` at a clk edge.
- `o_Tx_Data`  out  1  serial line; idle high.
- `o_Tx_Active`  out  1  frame on the line.
- `o_Tx_Done`  out  1  one-clk pulse when a frame's last stop bit completes.

## Operation
- Holding register stores {word, parity mode, two-stop} on transfer. Config is per frame; inputs are ignored outside a transfer.
- `o_Tx_Ready` = not hold_full; it is combinational from the flag. A transfer sets hold_full.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2. State advances only on clk edges where `i_Baud_Tick`=1.
- IDLE & hold_full & tick:
  - Load the shift register and per-frame config from hold and clear hold_full.
  - Drive 0 and go to START.
- START, tick: drive bit 0 and go to DATA. The bit counter starts at 0.
- DATA, tick:
  - If counter < DATA_BITS-1, drive the next bit and increment the counter.
  - Otherwise drive the parity bit and go to PARITY (parity enabled), or drive 1 and go to STOP1.
- Parity bit:
  - Even mode: XOR of the data bits.
  - Odd mode: inverse of that XOR.
- PARITY, tick: drive 1 and go to STOP1.
- STOP1, tick: if two-stop, go to STOP2 with the line held at 1. Otherwise the frame ends.
- STOP2, tick: the frame ends.
- Frame end, on the tick that closes the final stop bit:
  - Pulse `o_Tx_Done`.
  - If hold_full, start the next frame on the same edge: drive 0, go to START, clear hold_full.
  - Otherwise go to IDLE with the line at 1.
- `o_Tx_Active` = state != IDLE.
- Frame length in ticks: 1 + DATA_BITS + (parity ? 1 : 0) + (two-stop ? 2 : 1).

## Timing
- Reset values, registered on the first clk edge with `reset`=1:
  - `o_Tx_Data`=1, `o_Tx_Active`=0, `o_Tx_Done`=0, state IDLE.
  - hold_full=0, so `o_Tx_Ready`=1 on the cycle after reset.
- Reset mid-frame: the line returns to 1 at that edge, and both the current frame and the held word are discarded. No `o_Tx_Done` is generated.
- Accept-to-start latency:
  - Start bit is driven at the first tick edge strictly after the accepting edge, if idle.
  - If a tick coincides with the accept edge, the word starts on the following tick.
- Each line value is held from its driving tick edge to the next tick edge.
- `o_Tx_Done` is high for exactly one clk, the cycle after the final tick edge, independent of tick spacing.
- Ready behaviour:
  - `o_Tx_Ready` rises the cycle after hold is moved into the shift register.
  - A word presented while ready=0 is not accepted; the source holds it.
- Simultaneous frame end and transfer into an empty hold: the accept is registered, but the new word waits one full tick (idle high) before its start bit.
- Tick during IDLE with hold empty: no effect.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state encoding,
  - parity mode constants (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`),
  - `DATA_BITS` legal-range bounds for elaboration checks.
- One sub-module, `uart_tx_hold_reg`: the one-entry valid/ready holding register with a load/take interface, parametrised on payload width.

## Test plan
- 8N1, tick every clk, send 0x55 → line 0,1,0,1,0,1,0,1,0,1. `o_Tx_Active` high for 10 cycles. `o_Tx_Done` pulses once.
- 8E1 with 0xA5 → parity bit 0; 8O1 with 0xA5 → parity bit 1. Frame is 11 ticks.
- DATA_BITS=7, two stop bits, 0x3F → 0,1,1,1,1,1,1,0,1,1. 10 ticks, done after the second stop bit.
- 0x01 and 0x80 queued back-to-back, 8N1 → the second start bit follows the first stop bit with no idle tick. Two done pulses, 10 ticks apart.
- Tick every 16 clks: each bit held 16 clks; `o_Tx_Ready` stays 0 while hold is full and the source holds `i_Tx_Valid`.
- Reset asserted at data bit 3 with a word held → line 1 next edge, ready=1 after, no done. The next frame sends cleanly.
